// File: rtl/mci_arbiter_if.sv
// ============================================================================
// Module      : mci_pkg / mci_arbiter_if
// Description : Request/response types and the cache-side/memory-side bus
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mci_pkg;
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
  } mci_request_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] data;
  } mci_response_t;
endpackage

interface mci_arbiter_if #(
  parameter int N_PORTS = 2
);
  import mci_pkg::*;

  mci_request_t  req_in  [N_PORTS];
  mci_response_t res_out [N_PORTS];
  mci_request_t  mem_req;
  mci_response_t mem_res;

  // The arbiter is the slave of the cache ports and drives the memory side.
  modport slave  (input  req_in, input  mem_res, output res_out, output mem_req);
  modport master (output req_in, output mem_res, input  res_out, input  mem_req);
endinterface

`default_nettype wire

// File: rtl/mci_arbiter.sv
// ============================================================================
// Module      : mci_arbiter
// Description : Round-robin arbiter of N cache ports onto one memory channel
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mci_arbiter
  import mci_pkg::*;
#(
  parameter int N_PORTS = 2,
  localparam int c_grant_w = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mci_arbiter_if.slave         bus,
  output logic                 busy,
  output logic [c_grant_w-1:0] grant_id,
  output logic                 err_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [c_grant_w:0] c_nports = (c_grant_w + 1)'(N_PORTS);

  state_t               r_state;
  state_t               w_next_state;
  logic [N_PORTS-1:0]   r_pending;
  logic                 r_slot_rw   [N_PORTS];
  logic [31:0]          r_slot_addr [N_PORTS];
  logic [31:0]          r_slot_data [N_PORTS];
  logic [c_grant_w-1:0] r_grant;
  logic [c_grant_w-1:0] r_last_grant;
  logic                 r_req_rw;
  logic [31:0]          r_req_addr;
  logic [31:0]          r_req_data;
  logic                 r_err;

  logic [N_PORTS-1:0]   w_cand;
  logic                 w_found;
  logic [c_grant_w-1:0] w_winner;
  logic [c_grant_w:0]   w_sum;
  logic                 w_release;
  logic                 w_win_rw;
  logic [31:0]          w_win_addr;
  logic [31:0]          w_win_data;

  assign w_release = (r_state != IDLE) && bus.mem_res.ready;

  // Round-robin search starting just after the last winner; a same-cycle pulse counts.
  always_comb begin
    w_cand   = '0;
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_cand[i] = r_pending[i] | bus.req_in[i].valid;
    end
    for (int k = 1; k <= N_PORTS; k++) begin
      w_sum = {1'b0, r_last_grant} + (c_grant_w + 1)'(k);
      if (w_sum >= c_nports) begin
        w_sum = w_sum - c_nports;
      end
      if (!w_found && w_cand[w_sum[c_grant_w-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[c_grant_w-1:0];
      end
    end
  end

  // A fresh pulse is newer than whatever the slot holds.
  always_comb begin
    w_win_rw   = r_slot_rw[w_winner];
    w_win_addr = r_slot_addr[w_winner];
    w_win_data = r_slot_data[w_winner];
    if (bus.req_in[w_winner].valid) begin
      w_win_rw   = bus.req_in[w_winner].rw;
      w_win_addr = bus.req_in[w_winner].addr;
      w_win_data = bus.req_in[w_winner].data;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next_state = ISSUE;
      ISSUE:   w_next_state = w_release ? IDLE : WAIT;
      WAIT:    if (w_release) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_grant      <= '0;
      r_last_grant <= c_grant_w'(N_PORTS - 1);
      r_req_rw     <= 1'b0;
      r_req_addr   <= '0;
      r_req_data   <= '0;
      r_err        <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        r_slot_rw[i]   <= 1'b0;
        r_slot_addr[i] <= '0;
        r_slot_data[i] <= '0;
      end
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_found) begin
        r_req_rw     <= w_win_rw;
        r_req_addr   <= w_win_addr;
        r_req_data   <= w_win_data;
        r_grant      <= w_winner;
        r_last_grant <= w_winner;
      end
      // A new pulse wins over a release of the same slot.
      for (int i = 0; i < N_PORTS; i++) begin
        if (bus.req_in[i].valid) begin
          r_pending[i]   <= 1'b1;
          r_slot_rw[i]   <= bus.req_in[i].rw;
          r_slot_addr[i] <= bus.req_in[i].addr;
          r_slot_data[i] <= bus.req_in[i].data;
          if (r_pending[i] && !(w_release && (r_grant == c_grant_w'(i)))) begin
            r_err <= 1'b1;
          end
        end else if (w_release && (r_grant == c_grant_w'(i))) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.mem_req = '{valid: (r_state == ISSUE), rw: r_req_rw,
                         addr: r_req_addr, data: r_req_data};

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      bus.res_out[i] = '{ready: w_release && (r_grant == c_grant_w'(i)),
                         data: bus.mem_res.data};
    end
  end

  assign busy         = (r_state != IDLE);
  assign grant_id     = r_grant;
  assign err_overflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mci_arbiter.sv
// ============================================================================
// Module      : tb_mci_arbiter
// Description : Scoreboard bench for mci_arbiter with two cache ports
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mci_arbiter;
  import mci_pkg::*;

  localparam int N = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [0:0] grant_id;
  logic       err_overflow;

  mci_arbiter_if #(.N_PORTS(N)) ifc ();

  mci_arbiter #(.N_PORTS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (ifc.slave),
    .busy         (busy),
    .grant_id     (grant_id),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   n_issued  = 0;
  int   n_resp    = 0;

  // Scoreboard: every issued memory request is matched against the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (ifc.mem_req.valid === 1'b1) begin
        n_issued++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL issue_unexpected: got port=%0d addr=%h, required no issue", grant_id, ifc.mem_req.addr);
        end else begin
          e = sb.pop_front();
          if (int'(grant_id) !== e.port || ifc.mem_req.addr !== e.addr ||
              ifc.mem_req.data !== e.data || ifc.mem_req.rw !== e.rw) begin
            failures++;
            $display("FAIL issue_match: got port=%0d addr=%h data=%h rw=%b, required port=%0d addr=%h data=%h rw=%b",
                     grant_id, ifc.mem_req.addr, ifc.mem_req.data, ifc.mem_req.rw,
                     e.port, e.addr, e.data, e.rw);
          end
        end
      end
      for (int p = 0; p < N; p++) begin
        if (ifc.res_out[p].ready === 1'b1) n_resp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) ifc.req_in[p].valid = 1'b0;
    ifc.mem_res.ready = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] d, input logic rw);
    ifc.req_in[p] = '{valid: 1'b1, rw: rw, addr: a, data: d};
  endtask

  task automatic drive_resp(input logic [31:0] d);
    ifc.mem_res = '{ready: 1'b1, data: d};
  endtask

  task automatic push_exp(input int p, input logic [31:0] a, input logic [31:0] d, input logic rw);
    exp_t e;
    e.port = p; e.addr = a; e.data = d; e.rw = rw;
    sb.push_back(e);
  endtask

  // Bounded wait for the next mem_req.valid; ends at the negedge of that cycle.
  task automatic wait_issue(input string tag);
    bit seen = 1'b0;
    int cnt  = 0;
    while (!seen && cnt < 20) begin
      tick();
      @(negedge clk);
      seen = (ifc.mem_req.valid === 1'b1);
      cnt++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no mem_req.valid in 20 cycles, required an issue", tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < N; p++) ifc.req_in[p] = '0;
    ifc.mem_res = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int p = 0; p < N; p++) ifc.req_in[p] = '0;
    ifc.mem_res = '0;
    #2;
    checks++;
    if (busy !== 1'b0 || ifc.mem_req !== '0 || grant_id !== 1'b0 || err_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b mem_req=%h grant=%b err=%b, required all 0",
               busy, ifc.mem_req, grant_id, err_overflow);
    end
    checks++;
    if (ifc.res_out[0].ready !== 1'b0 || ifc.res_out[1].ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_res_ready: got %b%b, required 00", ifc.res_out[1].ready, ifc.res_out[0].ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ifc.mem_req.valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy, ifc.mem_req.valid);
    end
  endtask

  task automatic test_single();
    tick();
    set_req(1, 32'h0000_1000, 32'hDEAD_0001, 1'b0);
    push_exp(1, 32'h0000_1000, 32'hDEAD_0001, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if (ifc.mem_req.valid !== 1'b1 || grant_id !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: got valid=%b grant=%b, required 1 1", ifc.mem_req.valid, grant_id);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ifc.mem_req.valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_wait: got valid=%b busy=%b, required 0 1", ifc.mem_req.valid, busy);
    end
    tick();
    tick();
    drive_resp(32'hCAFE_0001);
    @(negedge clk);
    checks++;
    if (ifc.res_out[1].ready !== 1'b1 || ifc.res_out[0].ready !== 1'b0 ||
        ifc.res_out[0].data !== 32'hCAFE_0001 || ifc.res_out[1].data !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL single_resp: got rdy1=%b rdy0=%b d0=%h d1=%h, required 1 0 cafe0001 cafe0001",
               ifc.res_out[1].ready, ifc.res_out[0].ready, ifc.res_out[0].data, ifc.res_out[1].data);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_req(0, 32'h0000_0010, 32'h0000_00A0, 1'b0);
    set_req(1, 32'h0000_0020, 32'h0000_00B0, 1'b1);
    push_exp(0, 32'h0000_0010, 32'h0000_00A0, 1'b0);
    push_exp(1, 32'h0000_0020, 32'h0000_00B0, 1'b1);
    tick();
    @(negedge clk);
    checks++;
    if (ifc.mem_req.valid !== 1'b1 || grant_id !== 1'b0) begin
      failures++;
      $display("FAIL simul_first: got valid=%b grant=%b, required 1 0", ifc.mem_req.valid, grant_id);
    end
    tick();
    drive_resp(32'h1);
    @(negedge clk);
    checks++;
    if (ifc.res_out[0].ready !== 1'b1 || ifc.res_out[1].ready !== 1'b0) begin
      failures++;
      $display("FAIL simul_resp0: got rdy0=%b rdy1=%b, required 1 0", ifc.res_out[0].ready, ifc.res_out[1].ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ifc.mem_req.valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_gap: got valid=%b one cycle after response, required 0", ifc.mem_req.valid);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ifc.mem_req.valid !== 1'b1 || grant_id !== 1'b1) begin
      failures++;
      $display("FAIL simul_second: got valid=%b grant=%b, required 1 1", ifc.mem_req.valid, grant_id);
    end
    tick();
    drive_resp(32'h2);
    @(negedge clk);
    tick();
  endtask

  task automatic test_fairness();
    logic [31:0] slot [N];
    do_reset();
    slot[0] = 32'h0000_0100;
    slot[1] = 32'h0000_0200;
    set_req(0, slot[0], 32'h0, 1'b0);
    set_req(1, slot[1], 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      push_exp(i % 2, slot[i % 2], 32'h0, 1'b0);
      wait_issue("fair");
      checks++;
      if (int'(grant_id) !== i % 2) begin
        failures++;
        $display("FAIL fair_grant%0d: got grant=%0d, required %0d", i, grant_id, i % 2);
      end
      tick();
      drive_resp(32'h100 + i);
      if (i < 5) begin
        slot[i % 2] = slot[i % 2] + 32'h10;
        set_req(i % 2, slot[i % 2], 32'h0, 1'b0);
      end
      @(negedge clk);
    end
    tick();
  endtask

  task automatic test_wb_alloc();
    do_reset();
    set_req(1, 32'h0000_A000, 32'h0000_0AAA, 1'b1);
    push_exp(1, 32'h0000_A000, 32'h0000_0AAA, 1'b1);
    wait_issue("wb");
    tick();
    drive_resp(32'h3);
    set_req(1, 32'h0000_B000, 32'h0, 1'b0);
    push_exp(1, 32'h0000_B000, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (ifc.res_out[1].ready !== 1'b1) begin
      failures++;
      $display("FAIL wb_resp: got rdy1=%b, required 1", ifc.res_out[1].ready);
    end
    wait_issue("alloc");
    checks++;
    if (err_overflow !== 1'b0 || grant_id !== 1'b1) begin
      failures++;
      $display("FAIL alloc_state: got err=%b grant=%b, required 0 1", err_overflow, grant_id);
    end
    tick();
    drive_resp(32'h4);
    @(negedge clk);
    tick();
  endtask

  task automatic test_overflow();
    int r0;
    do_reset();
    r0 = n_resp;
    set_req(1, 32'h0000_1111, 32'h0, 1'b0);
    push_exp(1, 32'h0000_1111, 32'h0, 1'b0);
    wait_issue("ovf_p1");
    tick();
    set_req(0, 32'h0000_2222, 32'h0, 1'b0);
    tick();
    set_req(0, 32'h0000_3333, 32'h0000_0033, 1'b1);
    tick();
    @(negedge clk);
    checks++;
    if (err_overflow !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: got err=%b busy=%b, required 1 1", err_overflow, busy);
    end
    tick();
    drive_resp(32'h5);
    push_exp(0, 32'h0000_3333, 32'h0000_0033, 1'b1);
    @(negedge clk);
    wait_issue("ovf_p0");
    tick();
    drive_resp(32'h6);
    @(negedge clk);
    tick();
    drive_resp(32'h7);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ifc.res_out[0].ready !== 1'b0 || ifc.res_out[1].ready !== 1'b0) begin
      failures++;
      $display("FAIL stray_resp: got busy=%b rdy0=%b rdy1=%b, required 0 0 0",
               busy, ifc.res_out[0].ready, ifc.res_out[1].ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ifc.mem_req.valid !== 1'b0 || err_overflow !== 1'b1 || (n_resp - r0) !== 2) begin
      failures++;
      $display("FAIL stray_after: got busy=%b valid=%b err=%b pulses=%0d, required 0 0 1 2",
               busy, ifc.mem_req.valid, err_overflow, n_resp - r0);
    end
  endtask

  task automatic test_reset_mid_wait();
    int r0;
    tick();
    set_req(1, 32'h0000_5555, 32'h0, 1'b0);
    push_exp(1, 32'h0000_5555, 32'h0, 1'b0);
    wait_issue("rstw");
    tick();
    r0 = n_resp;
    drive_resp(32'h8);
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ifc.mem_req !== '0 || grant_id !== 1'b0 || err_overflow !== 1'b0 ||
        ifc.res_out[0].ready !== 1'b0 || ifc.res_out[1].ready !== 1'b0) begin
      failures++;
      $display("FAIL rstw_async: got busy=%b mem_req=%h grant=%b err=%b rdy=%b%b, required all 0",
               busy, ifc.mem_req, grant_id, err_overflow, ifc.res_out[1].ready, ifc.res_out[0].ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ifc.mem_res = '0;
    tick();
    drive_resp(32'h9);
    @(negedge clk);
    checks++;
    if (ifc.res_out[0].ready !== 1'b0 || ifc.res_out[1].ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstw_late_resp: got rdy=%b%b busy=%b, required 00 0",
               ifc.res_out[1].ready, ifc.res_out[0].ready, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ifc.mem_req.valid !== 1'b0 || n_resp !== r0) begin
      failures++;
      $display("FAIL rstw_quiet: got valid=%b pulses=%0d, required 0 0", ifc.mem_req.valid, n_resp - r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_wb_alloc();
    test_overflow();
    test_reset_mid_wait();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL sb_drained: got %0d expected issues left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mci_arbiter.md
MCI_ARBITER -- requirements
Module: mci_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2, SHALL set the number of cache requesters (2..8); port 0 is icache and port 1 is dcache by convention.
REQ-002 Clock and reset SHALL be `clk` and `rst`: a single clock, with reset asynchronous and active-high.
REQ-003 `clk`  input  1  rising-edge clock for all state.
REQ-004 `rst`  input  1  asynchronous active-high reset.
REQ-005 `req_in[N_PORTS]`  input  mci_request_t  per-port request; valid is a 1-cycle pulse, and addr/data/rw are meaningful only while valid=1.
REQ-006 `res_out[N_PORTS]`  output  mci_response_t  per-port response; ready is a 1-cycle pulse.
REQ-007 `mem_req`  output  mci_request_t  request to the memory controller.
REQ-008 `mem_res`  input  mci_response_t  response from the memory controller.
REQ-009 `busy`  output  1  high whenever the state is not IDLE.
REQ-010 `grant_id`  output  $clog2(N_PORTS) (min 1)  port owning the current or most recent transaction.
REQ-011 `err_overflow`  output  1  sticky flag; it is set when a pulse arrives on a port whose slot is already pending and is not being released that cycle.

Function
REQ-012 Each port SHALL have a one-entry pending slot (addr, data, rw), loaded on the clock edge where req_in[i].valid=1.
REQ-013 The candidate set SHALL be pending[i] OR req_in[i].valid; an incoming pulse is eligible for grant in the same cycle it arrives.
REQ-014 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-015 IDLE with a non-empty candidate set SHALL move to ISSUE at the edge. At that edge it registers the winner's addr/data/rw into mem_req, records grant_id, and updates the round-robin pointer.
REQ-016 In ISSUE, mem_req.valid SHALL be 1 for exactly one cycle, then the FSM moves to WAIT.
REQ-017 In IDLE and WAIT, mem_req.valid SHALL be 0; mem_req.addr/data/rw hold their last values.
REQ-018 Arbitration SHALL be round-robin: the search starts at (last_grant+1) mod N_PORTS, and the first candidate found wins.
REQ-019 While in ISSUE or WAIT, mem_res.ready=1 SHALL combinationally drive res_out[grant_id].ready=1 in the same cycle. The FSM then goes to IDLE and pending[grant_id] is cleared at that edge.
REQ-020 res_out[*].data SHALL equal mem_res.data for all ports; res_out[i].ready SHALL be 0 for every i other than grant_id.
REQ-021 mem_res.ready in IDLE SHALL be ignored: no res_out pulse and no state change.
REQ-022 Release and a new pulse on the same port in the same cycle (dcache write-back followed by allocate) SHALL leave that slot pending with the new request; the set takes priority over the clear.
REQ-023 A pulse on a port already pending and not being released SHALL overwrite the slot with the new request and set err_overflow.
REQ-024 A port that is not granted SHALL keep its pending slot indefinitely.
REQ-025 With round-robin arbitration, a pending port SHALL be granted within N_PORTS transactions.
REQ-026 Minimum latency from a request pulse in cycle N, with the FSM in IDLE, SHALL be mem_req.valid=1 in cycle N+1.
REQ-027 The back-to-back gap SHALL be: response ready in cycle M leads to the next mem_req.valid no earlier than M+2.

Reset
REQ-028 On rst assertion, asynchronously and irrespective of state:
- state=IDLE
- all pending slots cleared
- mem_req.valid=0, with addr/data/rw set to 0
- res_out[*].ready=0
- grant_id=0
- err_overflow=0
- last_grant=N_PORTS-1, so port 0 wins the first tie
REQ-029 A reset asserted mid-transaction SHALL abandon that transaction without emitting any res_out pulse. A mem_res.ready arriving after deassertion SHALL be ignored per REQ-021.

Verification
REQ-030 Single request: port 1 pulses addr=0x0000_1000, rw=0 in cycle 5. Required: mem_req.valid=1 with addr 0x1000 in cycle 6 only; mem_res.ready in cycle 9 gives res_out[1].ready=1 in cycle 9, res_out[0].ready=0, and busy=0 from cycle 10.
REQ-031 Simultaneous requests: ports 0 and 1 pulse together out of reset. Required: port 0 is granted first; after its response, port 1 is issued and mem_req.valid rises two cycles after that response.
REQ-032 Fairness: ports 0 and 1 re-request continuously for 6 transactions. Required: grant_id sequence is 0,1,0,1,0,1.
REQ-033 Write-back then allocate: port 1 pulses rw=1 at addr 0xA000; in the response cycle it pulses rw=0 at addr 0xB000. Required: a second mem_req for 0xB000 with rw=0 is issued and err_overflow stays 0.
REQ-034 Overflow and stray response: port 0 pulses twice while port 1 owns the bus, and mem_res.ready is driven during IDLE. Required: err_overflow=1, the second request wins, and there are no res_out pulses.
REQ-035 Reset mid-WAIT: rst is asserted for 1 cycle while in WAIT. Required: all outputs reach their reset values before the next clock edge, and a later mem_res.ready produces no response.
